// File: rtl/vga_write_arbiter.sv
// Pixel-write arbiter for the 160x120 VGA adapter: realigns the picture
// stream with its colour and shares the port with a stallable game source. Option: VGA_CLIP_EN.
module vga_write_arbiter #(
  parameter int PIC_LAT = 2,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pic_drawing,
  input  logic [9:0] pic_x,
  input  logic [9:0] pic_y,
  input  logic [2:0] pic_colour,
  input  logic       game_req,
  input  logic       game_plot,
  input  logic [7:0] game_x,
  input  logic [6:0] game_y,
  input  logic [2:0] game_colour,
  output logic       game_grant,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    PIC,
    DRAIN,
    GAME
  } state_e;

  typedef struct packed {
    logic       drw;
    logic       oob;
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  pix_t       dly_q [PIC_LAT];
  pix_t       pic_in;
  pix_t       pic_out;
  logic       pic_oob;
  logic       game_oob;

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] col_q, col_d;
  logic       plot_q, plot_d;

  logic       pic_act;
  logic       game_wr;

`ifdef VGA_CLIP_EN
  assign pic_oob  = (pic_x >= 10'(SCR_W))
                 || (pic_y >= 10'(SCR_H));
  assign game_oob = ({2'b0, game_x} >= 10'(SCR_W))
                 || ({3'b0, game_y} >= 10'(SCR_H));
`else
  logic unused_clip;
  assign pic_oob     = 1'b0;
  assign game_oob    = 1'b0;
  assign unused_clip = ^{pic_x[9:8], pic_y[9:7],
                         SCR_W[0], SCR_H[0]};
`endif

  assign pic_in = '{drw: pic_drawing,
                    oob: pic_oob,
                    x:   pic_x[7:0],
                    y:   pic_y[6:0]};

  // Free-running delay line: never stalls, so DRAIN->PIC loses nothing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PIC_LAT; i++)
        dly_q[i] <= '0;
    end else begin
      dly_q[0] <= pic_in;
      for (int i = 1; i < PIC_LAT; i++)
        dly_q[i] <= dly_q[i-1];
    end
  end

  assign pic_out = dly_q[PIC_LAT-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pic_drawing)
          state_d = PIC;
        else if (game_req)
          state_d = GAME;
      end
      PIC: begin
        if (!pic_drawing) begin
          state_d = DRAIN;
          cnt_d   = 3'(PIC_LAT);
        end
      end
      DRAIN: begin
        if (pic_drawing)
          state_d = PIC;
        else if (cnt_q == 3'd1)
          state_d = IDLE;
        else
          cnt_d = cnt_q - 3'd1;
      end
      GAME: begin
        if (pic_drawing)
          state_d = PIC;
        else if (!game_req)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A game pixel in the preempting cycle is dropped; the source re-presents it
  assign pic_act = (state_q == PIC) || (state_q == DRAIN);
  assign game_wr = (state_q == GAME) && game_plot
                && !pic_drawing;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    col_d  = col_q;
    plot_d = 1'b0;
    if (pic_act) begin
      x_d    = pic_out.x;
      y_d    = pic_out.y;
      col_d  = pic_colour;
      plot_d = pic_out.drw && !pic_out.oob;
    end else if (game_wr) begin
      x_d    = game_x;
      y_d    = game_y;
      col_d  = game_colour;
      plot_d = !game_oob;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= '0;
      plot_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      col_q  <= col_d;
      plot_q <= plot_d;
    end
  end

  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign vga_plot   = plot_q;
  assign game_grant = (state_q == GAME);
  assign busy       = (state_q != IDLE);

endmodule
